// File: rtl/axi_responder_defs.sv
// axi_responder_defs: shared state encoding and channel widths for the AXI SRAM responder
package axi_responder_defs;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, WRITE_DATA, WRITE_RESP, READ_DATA} state_e;
endpackage

// File: rtl/axi_read_skid_buffer.sv
// axi_read_skid_buffer: 2-entry FIFO holding SRAM read beats and their last flags
module axi_read_skid_buffer
  import axi_responder_defs::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [AXI_DATA_WIDTH-1:0] push_data,
  input  logic                      push_last,
  input  logic                      pop,
  output logic                      head_valid,
  output logic [AXI_DATA_WIDTH-1:0] head_data,
  output logic                      head_last,
  output logic [1:0]                occupancy
);
  logic [1:0][AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0] last_q, last_d, cnt_q, cnt_d;
  logic wr_q, wr_d, rd_q, rd_d;
  // Store the incoming beat at the tail and advance both pointers
  always_comb begin
    data_d = data_q;
    last_d = last_q;
    if (push) begin
      data_d[wr_q] = push_data;
      last_d[wr_q] = push_last;
    end
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  // Storage, pointers and occupancy; reset empties the buffer and zeroes its contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      last_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end
  assign head_valid = cnt_q != 2'd0;
  assign head_data  = data_q[rd_q];
  assign head_last  = last_q[rd_q];
  assign occupancy  = cnt_q;
endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI burst slave turning bursts into single-port synchronous SRAM word accesses
module axi_sram_responder
  import axi_responder_defs::*;
#(
  parameter int SRAM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                axi_awaddr,
  input  logic [AXI_LEN_WIDTH-1:0]   axi_awlen,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]  axi_wdata,
  input  logic                       axi_wlast,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [31:0]                axi_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]   axi_arlen,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic                       axi_rvalid,
  input  logic                       axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]  axi_rdata,
  output logic                       axi_rlast,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we,
  output logic                       sram_re,
  output logic [AXI_DATA_WIDTH-1:0]  sram_wdata,
  input  logic [AXI_DATA_WIDTH-1:0]  sram_rdata,
  output logic                       protocol_error
);
  localparam int AW = SRAM_ADDR_WIDTH;
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AXI_LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
  logic [AXI_LEN_WIDTH:0] issued_q, issued_d;
  logic pend_q, pend_d, pend_last_q, pend_last_d, err_q, err_d;
  logic awready_q, wready_q, bvalid_q;
  logic aw_hs, ar_hs, w_hs, r_hs, issue, buf_last;
  logic [1:0] occ;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[31:AW+2], axi_awaddr[1:0], axi_araddr[31:AW+2], axi_araddr[1:0]};
  assign axi_awready = awready_q;
  assign axi_arready = awready_q & ~axi_awvalid;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign aw_hs = axi_awready & axi_awvalid;
  assign ar_hs = axi_arready & axi_arvalid;
  assign w_hs  = wready_q & axi_wvalid;
  assign r_hs  = axi_rvalid & axi_rready;
  // A read is issued only while beats remain and the buffer can absorb it, counting a same-cycle pop as freed space
  assign issue = (state_q == READ_DATA) && (issued_q <= {1'b0, len_q}) &&
                 (({1'b0, occ} + {2'b0, pend_q} - {2'b0, r_hs}) < 3'd2);
  assign sram_we        = w_hs;
  assign sram_re        = issue;
  assign sram_addr      = addr_q;
  assign sram_wdata     = w_hs ? axi_wdata : '0;
  assign axi_rlast      = axi_rvalid & buf_last;
  assign protocol_error = err_q;
  // Burst sequencing: address/beat bookkeeping, wlast checking and state transitions
  always_comb begin
    addr_d      = aw_hs ? axi_awaddr[AW+1:2] : ar_hs ? axi_araddr[AW+1:2] :
                  (w_hs || issue) ? addr_q + 1'b1 : addr_q;
    len_d       = aw_hs ? axi_awlen : ar_hs ? axi_arlen : len_q;
    beat_d      = aw_hs ? '0 : w_hs ? beat_q + 1'b1 : beat_q;
    issued_d    = ar_hs ? '0 : issue ? issued_q + 1'b1 : issued_q;
    err_d       = err_q | (w_hs && (axi_wlast != (beat_q == len_q)));
    pend_d      = issue;
    pend_last_d = issued_q == {1'b0, len_q};
    state_d     = state_q;
    case (state_q)
      IDLE:       state_d = aw_hs ? WRITE_DATA : ar_hs ? READ_DATA : IDLE;
      WRITE_DATA: state_d = (w_hs && beat_q == len_q) ? WRITE_RESP : WRITE_DATA;
      WRITE_RESP: state_d = axi_bready ? IDLE : WRITE_RESP;
      READ_DATA:  state_d = (r_hs && buf_last) ? IDLE : READ_DATA;
      default:    state_d = IDLE;
    endcase
  end
  // FSM state, counters and registered channel-ready outputs; reset forces every output low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      issued_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      err_q       <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      issued_q    <= issued_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      err_q       <= err_d;
      awready_q   <= state_d == IDLE;
      wready_q    <= state_d == WRITE_DATA;
      bvalid_q    <= state_d == WRITE_RESP;
    end
  end
  axi_read_skid_buffer u_rbuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (pend_q),
    .push_data  (sram_rdata),
    .push_last  (pend_last_q),
    .pop        (r_hs),
    .head_valid (axi_rvalid),
    .head_data  (axi_rdata),
    .head_last  (buf_last),
    .occupancy  (occ)
  );
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed bench with a burst-level memory model and a per-cycle compare process
module tb_axi_sram_responder;
  localparam int DEPTH = 65536;
  logic clk, reset_n;
  logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata, sram_wdata, sram_rdata;
  logic [7:0] axi_awlen, axi_arlen;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [15:0] sram_addr;
  logic sram_we, sram_re, protocol_error;
  logic [88:0] ovec;

  axi_sram_responder #(.SRAM_ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .protocol_error(protocol_error)
  );

  assign ovec = {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast, axi_rdata,
                 sram_addr, sram_we, sram_re, sram_wdata, protocol_error};

  typedef struct { logic [15:0] a; logic [31:0] d; } wexp_t;
  typedef struct { logic [31:0] d; logic l; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  logic [31:0] exp_mem [0:DEPTH-1];
  logic [31:0] mem [0:DEPTH-1];
  int checks = 0, errors = 0, cyc = 0;
  int we_count = 0, rlast_count = 0, out_cnt = 0, ar_cyc = 0, b_cyc = 0;
  logic [15:0] last_we_addr = '0;
  logic [31:0] last_rdata = '0;
  logic err_exp = 1'b0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the burst-level model
  initial begin
    logic stall_v;
    logic [31:0] stall_d;
    wexp_t we;
    rexp_t re;
    stall_v = 0;
    stall_d = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("outputs_zero_in_reset", {63'b0, |ovec}, 64'd0);
        out_cnt = 0;
        stall_v = 0;
      end else begin
        if (sram_we || sram_re) chk("we_re_exclusive", {63'b0, sram_we & sram_re}, 64'd0);
        if (sram_we) begin
          we_count++;
          last_we_addr = sram_addr;
          if (wq.size() == 0) chk("unexpected_sram_write", 64'd1, 64'd0);
          else begin
            we = wq.pop_front();
            chk("sram_write_addr", {48'b0, sram_addr}, {48'b0, we.a});
            chk("sram_write_data", {32'b0, sram_wdata}, {32'b0, we.d});
          end
        end
        if (sram_re) out_cnt++;
        if (stall_v) begin
          chk("stall_rvalid_held", {63'b0, axi_rvalid}, 64'd1);
          chk("stall_rdata_held", {32'b0, axi_rdata}, {32'b0, stall_d});
        end
        if (axi_rvalid && axi_rready) begin
          out_cnt--;
          last_rdata = axi_rdata;
          rlast_count += int'(axi_rlast);
          if (rq.size() == 0) chk("unexpected_read_beat", 64'd1, 64'd0);
          else begin
            re = rq.pop_front();
            chk("read_data", {32'b0, axi_rdata}, {32'b0, re.d});
            chk("read_last", {63'b0, axi_rlast}, {63'b0, re.l});
          end
        end
        if (sram_re) chk("outstanding_le_2", {63'b0, out_cnt <= 2}, 64'd1);
        stall_v = axi_rvalid && !axi_rready;
        stall_d = axi_rdata;
        chk("protocol_error", {63'b0, protocol_error}, {63'b0, err_exp});
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len, input logic [31:0] base, input int wl_beat);
    int n;
    logic hs;
    logic [15:0] w;
    axi_awaddr = addr;
    axi_awlen = len[7:0];
    axi_awvalid = 1;
    n = 0;
    do begin
      @(negedge clk);
      hs = axi_awready;
      if (hs) for (int i = 0; i <= len; i++) begin
        w = 16'((addr / 4 + i) % DEPTH);
        exp_mem[w] = base + i;
        wq.push_back('{a: w, d: base + i});
      end
      n++;
      tick;
    end while (!hs && n < 200);
    chk("aw_handshake", {63'b0, hs}, 64'd1);
    axi_awvalid = 0;
    for (int b = 0; b <= len; b++) begin
      axi_wdata = base + b;
      axi_wlast = (b == wl_beat);
      axi_wvalid = 1;
      n = 0;
      do begin
        @(negedge clk);
        hs = axi_wready;
        n++;
        tick;
      end while (!hs && n < 50);
      chk("w_handshake", {63'b0, hs}, 64'd1);
      if ((b == wl_beat) != (b == len)) err_exp = 1;
    end
    axi_wvalid = 0;
    axi_wlast = 0;
    @(negedge clk);
    chk("bvalid_after_last_beat", {63'b0, axi_bvalid}, 64'd1);
    b_cyc = cyc;
    tick;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] pat, input int abort_at);
    int n, t, first, lastc, beats;
    logic hs, done;
    axi_araddr = addr;
    axi_arlen = len[7:0];
    axi_arvalid = 1;
    n = 0;
    t = 0;
    do begin
      @(negedge clk);
      hs = axi_arready && axi_arvalid;
      t = cyc;
      if (hs) for (int i = 0; i <= len; i++)
        rq.push_back('{d: exp_mem[16'((addr / 4 + i) % DEPTH)], l: (i == len)});
      n++;
      tick;
    end while (!hs && n < 200);
    chk("ar_handshake", {63'b0, hs}, 64'd1);
    axi_arvalid = 0;
    ar_cyc = t;
    first = -1;
    lastc = -1;
    beats = 0;
    done = 0;
    n = 0;
    while (!done && n < 2000) begin
      axi_rready = pat[n % 4];
      @(negedge clk);
      if (axi_rvalid && first < 0) first = cyc;
      if (axi_rvalid && axi_rready) begin
        beats++;
        if (axi_rlast) begin
          done = 1;
          lastc = cyc;
        end
      end
      n++;
      tick;
      if (abort_at != 0 && beats == abort_at) return;
    end
    axi_rready = 0;
    chk("read_burst_done", {63'b0, done}, 64'd1);
    chk("read_beat_count", 64'(beats), 64'(len + 1));
    chk("first_rvalid_latency", 64'(first - t), 64'd3);
    if (pat == 4'hF) chk("last_beat_cycle", 64'(lastc - t), 64'(3 + len));
  endtask

  initial begin
    reset_n = 0;
    axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 0;
    axi_wdata = '0; axi_wlast = 0; axi_wvalid = 0; axi_bready = 1;
    axi_araddr = '0; axi_arlen = '0; axi_arvalid = 0; axi_rready = 0;
    repeat (3) tick;
    chk("reset_state_outputs", {63'b0, |ovec}, 64'd0);
    reset_n = 1;
    tick;
    @(negedge clk);
    chk("awready_after_reset", {63'b0, axi_awready}, 64'd1);
    chk("arready_idle", {63'b0, axi_arready}, 64'd1);
    tick;

    // 16-beat write at 0x100, then read back with rready high
    we_count = 0;
    do_write(32'h100, 15, 32'hA0, 15);
    chk("write16_we_count", 64'(we_count), 64'd16);
    chk("write16_word_addr_last", {48'b0, last_we_addr}, 64'h4F);
    chk("write16_no_error", {63'b0, protocol_error}, 64'd0);
    rlast_count = 0;
    do_read(32'h100, 15, 4'hF, 0);
    chk("read16_last_data", {32'b0, last_rdata}, 64'hAF);
    chk("read16_rlast_count", 64'(rlast_count), 64'd1);

    // Same burst with rready pattern 1,0,0,1
    rlast_count = 0;
    do_read(32'h100, 15, 4'b1001, 0);
    chk("read16_stall_last_data", {32'b0, last_rdata}, 64'hAF);
    chk("read16_stall_rlast_count", 64'(rlast_count), 64'd1);

    // wlast asserted early on a 4-beat write
    we_count = 0;
    do_write(32'h300, 3, 32'h1234_0000, 1);
    chk("perr_we_count", 64'(we_count), 64'd4);
    chk("perr_set", {63'b0, protocol_error}, 64'd1);

    // AW and AR presented together: the write wins and the read sees its data
    fork
      do_write(32'h200, 3, 32'h5500_0000, 3);
      do_read(32'h200, 3, 4'hF, 0);
    join
    chk("ar_after_b_handshake", {63'b0, ar_cyc > b_cyc}, 64'd1);
    chk("simul_read_last_data", {32'b0, last_rdata}, 64'h5500_0003);
    chk("perr_sticky", {63'b0, protocol_error}, 64'd1);

    // Reset in the middle of a 16-beat read, after beat 5
    do_read(32'h100, 15, 4'hF, 5);
    reset_n = 0;
    err_exp = 0;
    #1;
    chk("reset_mid_read_outputs", {63'b0, |ovec}, 64'd0);
    rq.delete();
    wq.delete();
    axi_rready = 0;
    repeat (2) tick;
    reset_n = 1;
    tick;
    @(negedge clk);
    chk("awready_after_mid_reset", {63'b0, axi_awready}, 64'd1);
    chk("perr_cleared_by_reset", {63'b0, protocol_error}, 64'd0);
    tick;

    // Two-beat burst at the top word wraps to word 0; read back through an aliased address
    do_write(32'h0003_FFFC, 1, 32'hC0DE_0000, 1);
    chk("wrap_last_word_addr", {48'b0, last_we_addr}, 64'd0);
    do_read(32'hC003_FFFC, 1, 4'hF, 0);
    chk("wrap_read_last_data", {32'b0, last_rdata}, 64'hC0DE_0001);

    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
